// File: rtl/spike_neo_detector.sv
// Nonlinear energy operator spike detector: psi = x[n-1]^2 - x[n]*x[n-2] on offset-binary samples,
// thresholded with a refractory window and a saturating detection counter.
module spike_neo_detector #(
  parameter int BITSIZE    = 16,
  parameter int REFRAC_LEN = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      EN,
  input  logic [BITSIZE-1:0]        DATA_IN,
  input  logic                      DATA_VALID,
  input  logic [2*BITSIZE-1:0]      THRESHOLD,
  output logic signed [2*BITSIZE:0] NEO_OUT,
  output logic                      NEO_VALID,
  output logic                      SPIKE_FLAG,
  output logic [CNT_WIDTH-1:0]      SPIKE_CNT,
  output logic                      BUSY
);

  // state   | meaning
  // IDLE    | block disabled or just enabled
  // WARMUP  | collecting the first three samples
  // ARMED   | detection active
  // REFRACT | detections ignored until REFRAC_LEN NEO samples pass
  typedef enum logic [1:0] {IDLE, WARMUP, ARMED, REFRACT} state_t;

  localparam int RW = $clog2(REFRAC_LEN + 1);

  state_t state_q, state_d;
  logic dv_q, accept, v0, v1, detect, rcnt_tc, load_rcnt, dec_rcnt;
  logic [1:0] fill;
  logic [RW-1:0] rcnt;
  logic signed [BITSIZE-1:0] x_in, x0, x1, x2;
  logic signed [2*BITSIZE-1:0] x0_e, x1_e, x2_e, pa, pb;

  assign accept = EN & DATA_VALID & ~dv_q;
  assign x_in   = {~DATA_IN[BITSIZE-1], DATA_IN[BITSIZE-2:0]};
  assign x0_e   = {{BITSIZE{x0[BITSIZE-1]}}, x0};
  assign x1_e   = {{BITSIZE{x1[BITSIZE-1]}}, x1};
  assign x2_e   = {{BITSIZE{x2[BITSIZE-1]}}, x2};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) dv_q <= 1'b0;
    else       dv_q <= DATA_VALID;
  end

  // Three-stage pipeline: window shift, products, difference.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      x0 <= '0; x1 <= '0; x2 <= '0; fill <= '0;
      v0 <= 1'b0; v1 <= 1'b0; pa <= '0; pb <= '0;
      NEO_OUT <= '0; NEO_VALID <= 1'b0;
    end else if (!EN) begin
      x0 <= '0; x1 <= '0; x2 <= '0; fill <= '0;
      v0 <= 1'b0; v1 <= 1'b0; pa <= '0; pb <= '0;
      NEO_OUT <= '0; NEO_VALID <= 1'b0;
    end else begin
      if (accept) begin
        x2 <= x1;
        x1 <= x0;
        x0 <= x_in;
        fill <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
      end
      v0 <= accept && (fill >= 2'd2);
      pa <= x1_e * x1_e;
      pb <= x0_e * x2_e;
      v1 <= v0;
      NEO_VALID <= v1;
      if (v1) NEO_OUT <= {pa[2*BITSIZE-1], pa} - {pb[2*BITSIZE-1], pb};
    end
  end

  assign detect  = NEO_VALID && EN && (NEO_OUT > $signed({1'b0, THRESHOLD}));
  assign rcnt_tc = (rcnt == RW'(1));

  always_comb begin
    state_d    = state_q;
    SPIKE_FLAG = 1'b0;
    load_rcnt  = 1'b0;
    dec_rcnt   = 1'b0;
    if (!EN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = WARMUP;
        WARMUP:  if (fill == 2'd3) state_d = ARMED;
        ARMED: begin
          if (detect) begin
            SPIKE_FLAG = 1'b1;
            load_rcnt  = 1'b1;
            state_d    = REFRACT;
          end
        end
        REFRACT: begin
          if (NEO_VALID) begin
            dec_rcnt = 1'b1;
            if (rcnt_tc) state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      rcnt      <= '0;
      SPIKE_CNT <= '0;
    end else begin
      state_q <= state_d;
      if (!EN)            rcnt <= '0;
      else if (load_rcnt) rcnt <= RW'(REFRAC_LEN);
      else if (dec_rcnt)  rcnt <= rcnt - RW'(1);
      // Counter survives EN=0; only reset clears it.
      if (SPIKE_FLAG && (SPIKE_CNT != '1)) SPIKE_CNT <= SPIKE_CNT + CNT_WIDTH'(1);
    end
  end

  assign BUSY = (state_q == REFRACT);

endmodule

// File: tb/tb_spike_neo_detector.sv
// Self-checking bench for spike_neo_detector: directed literal cases plus randomized samples
// compared every cycle against a sample-history model of psi, refractory and counter rules.
module tb_spike_neo_detector;
  localparam int B    = 16;
  localparam int RLEN = 4;
  localparam int CW   = 4;

  logic                CLK = 1'b0;
  logic                nRST, EN, DATA_VALID;
  logic [B-1:0]        DATA_IN;
  logic [2*B-1:0]      THRESHOLD;
  logic signed [2*B:0] NEO_OUT;
  logic                NEO_VALID, SPIKE_FLAG, BUSY;
  logic [CW-1:0]       SPIKE_CNT;

  spike_neo_detector #(.BITSIZE(B), .REFRAC_LEN(RLEN), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .THRESHOLD(THRESHOLD), .NEO_OUT(NEO_OUT), .NEO_VALID(NEO_VALID),
    .SPIKE_FLAG(SPIKE_FLAG), .SPIKE_CNT(SPIKE_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0, cnum = 0;
  bit chk = 1'b0;

  // model state
  int     m_fill = 0, m_rem = 0, m_cnt = 0;
  int     h0 = 0, h1 = 0, h2 = 0;
  bit     m_pdv = 1'b0;
  longint m_neo = 0;
  int     q_cyc[$];
  longint q_psi[$];

  // expectations for the current cycle
  bit     exp_valid = 0, exp_flag = 0, exp_busy = 0;
  int     exp_cnt = 0;
  longint exp_neo = 0;

  // DUT activity captured for the directed literal checks
  int     cap_nv = 0, cap_flags = 0, cap_busy = 0;
  longint cap_neo = 0;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cnum, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk) begin
      check("neo_valid", NEO_VALID, exp_valid);
      check("spike_flag", SPIKE_FLAG, exp_flag);
      check("busy", BUSY, exp_busy);
      check("spike_cnt", SPIKE_CNT, exp_cnt);
      check("neo_out", NEO_OUT, exp_neo);
      if (NEO_VALID) begin
        cap_nv++;
        cap_neo = NEO_OUT;
        if (SPIKE_FLAG) cap_flags++;
        if (BUSY) cap_busy++;
      end
    end
  end

  task automatic clr_cap();
    cap_nv = 0; cap_flags = 0; cap_busy = 0;
  endtask

  // One clock cycle: drive inputs, derive this cycle's expected outputs, advance the model.
  task automatic cyc(input bit en_i, input bit dv_i, input logic [B-1:0] d_i);
    bit ev, acc;
    longint psi;
    int x;
    EN = en_i; DATA_VALID = dv_i; DATA_IN = d_i;
    ev = (q_cyc.size() > 0) && (q_cyc[0] == cnum);
    psi = 0;
    if (ev) begin
      psi = q_psi[0];
      void'(q_cyc.pop_front());
      void'(q_psi.pop_front());
      m_neo = psi;
    end
    exp_valid = ev;
    exp_neo   = m_neo;
    exp_busy  = (m_rem > 0);
    exp_cnt   = m_cnt;
    exp_flag  = ev && en_i && (m_rem == 0) && (psi > longint'(THRESHOLD));
    if (ev && en_i) begin
      if (m_rem > 0) m_rem--;
      else if (psi > longint'(THRESHOLD)) begin
        m_rem = RLEN;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
    acc = en_i && dv_i && !m_pdv;
    m_pdv = dv_i;
    if (acc) begin
      x = $signed(d_i ^ 16'h8000);
      h2 = h1; h1 = h0; h0 = x;
      if (m_fill < 3) m_fill++;
      if (m_fill == 3) begin
        q_cyc.push_back(cnum + 3);
        q_psi.push_back(longint'(h1) * h1 - longint'(h0) * h2);
      end
    end
    if (!en_i) begin
      m_fill = 0; m_rem = 0; m_neo = 0;
      q_cyc.delete(); q_psi.delete();
    end
    @(posedge CLK); #1;
    cnum++;
  endtask

  task automatic send(input logic [B-1:0] raw, input int hold, input int gap);
    for (int i = 0; i < hold; i++) cyc(1'b1, 1'b1, raw);
    for (int i = 0; i < gap; i++) cyc(1'b1, 1'b0, raw);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0);
  endtask

  task automatic en_off();
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic rst_mid();
    exp_valid = 0; exp_flag = 0; exp_busy = 0; exp_cnt = 0; exp_neo = 0;
    DATA_VALID = 1'b0;
    nRST = 1'b0;
    m_fill = 0; m_rem = 0; m_cnt = 0; m_neo = 0; m_pdv = 0;
    q_cyc.delete(); q_psi.delete();
    #1;
    check("rst_neo_valid", NEO_VALID, 0);
    check("rst_flag", SPIKE_FLAG, 0);
    check("rst_busy", BUSY, 0);
    check("rst_cnt", SPIKE_CNT, 0);
    check("rst_neo_out", NEO_OUT, 0);
    @(posedge CLK); #1; cnum++;
    @(posedge CLK); #1; cnum++;
    nRST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cnum);
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; EN = 1'b0; DATA_VALID = 1'b0; DATA_IN = '0; THRESHOLD = '0;
    #1;
    check("reset_neo_valid", NEO_VALID, 0);
    check("reset_neo_out", NEO_OUT, 0);
    check("reset_cnt", SPIKE_CNT, 0);
    check("reset_busy", BUSY, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    chk = 1'b1;

    // constant mid-scale: psi = 0, never above threshold 0
    THRESHOLD = 0; idle(2); clr_cap();
    for (int i = 0; i < 10; i++) send(16'h8000, 1, 2);
    idle(5);
    check("t1_nvalid", cap_nv, 8);
    check("t1_flags", cap_flags, 0);
    check("t1_neo", cap_neo, 0);

    // x = 0,100,0 -> psi = 10000
    en_off(); THRESHOLD = 5000; clr_cap();
    send(16'h8000, 1, 2); send(16'h8064, 1, 2); send(16'h8000, 1, 2); idle(5);
    check("t2_nvalid", cap_nv, 1);
    check("t2_neo", cap_neo, 10000);
    check("t2_flags", cap_flags, 1);
    check("t2_cnt", SPIKE_CNT, 1);
    en_off(); THRESHOLD = 10000; clr_cap();
    send(16'h8000, 1, 2); send(16'h8064, 1, 2); send(16'h8000, 1, 2); idle(5);
    check("t2b_nvalid", cap_nv, 1);
    check("t2b_neo", cap_neo, 10000);
    check("t2b_flags", cap_flags, 0);
    check("t2b_cnt", SPIKE_CNT, 1);

    // x = 100,100,200 -> psi = -10000
    en_off(); THRESHOLD = 0; clr_cap();
    send(16'h8064, 1, 2); send(16'h8064, 1, 2); send(16'h80C8, 1, 2); idle(5);
    check("t3_neo", cap_neo, -10000);
    check("t3_flags", cap_flags, 0);

    // full scale: x = -32768,-32768,32767
    en_off(); THRESHOLD = 0; clr_cap();
    send(16'h0000, 1, 2); send(16'h0000, 1, 2); send(16'hFFFF, 1, 2); idle(5);
    check("t6_neo", cap_neo, 64'sd2147450880);
    check("t6_flags", cap_flags, 1);
    check("t6_cnt", SPIKE_CNT, 2);

    // impulses every second sample with refractory of 4
    en_off(); THRESHOLD = 1000; clr_cap();
    send(16'h8000, 1, 2);
    for (int i = 0; i < 8; i++) begin
      send(16'h83E8, 1, 2);
      send(16'h8000, 1, 2);
    end
    idle(5);
    check("t4_nvalid", cap_nv, 15);
    check("t4_flags", cap_flags, 3);
    check("t4_busy_valids", cap_busy, 10);
    check("t4_cnt", SPIKE_CNT, 5);

    // held DATA_VALID gives one sample each; then reset with a sample in flight
    en_off(); THRESHOLD = 0; clr_cap();
    send(16'h8100, 5, 2); send(16'h8200, 5, 2); send(16'h8100, 5, 2); idle(5);
    check("t5_nvalid", cap_nv, 1);
    check("t5_neo", cap_neo, 196608);
    send(16'h8100, 1, 2); send(16'h8200, 1, 2); send(16'h8100, 1, 0);
    rst_mid();
    clr_cap();
    idle(6);
    check("t5_after_rst", cap_nv, 0);
    send(16'h8100, 1, 2); send(16'h8200, 1, 2); idle(5);
    check("t5_two_samples", cap_nv, 0);
    send(16'h8100, 1, 2); idle(5);
    check("t5_third_sample", cap_nv, 1);

    // randomized samples, pulse shapes, thresholds and enable drops
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0:       THRESHOLD = 32'($urandom_range(0, 2000));
        1:       THRESHOLD = 32'($urandom_range(0, 32'h3FFF_FFFF));
        default: THRESHOLD = $urandom;
      endcase
      if ($urandom_range(0, 39) == 0) en_off();
      if (n == 300) rst_mid();
      send(16'($urandom_range(0, 65535)), $urandom_range(1, 3), $urandom_range(1, 3));
    end
    idle(6);

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
